mem_wb_stage: RTL

//  MEM->WB pipeline register and write-back stage of the 5-stage MIPS core. It latches
//  MEM-stage results and aligns load data returned by the synchronous data RAM.
//  It drives the regfile write port (we/waddr/wdata) and owns the HI/LO pair, which
//  is committed here and read back with same-cycle bypass.

---
 rtl/mem_wb_stage_pkg.sv | 37 +++
 rtl/mem_wb_stage_if.sv | 38 +++
 rtl/mem_wb_stage_hilo_reg.sv | 42 ++++
 rtl/mem_wb_stage.sv | 113 +++++++++++
 4 files changed

// File: rtl/mem_wb_stage_pkg.sv
// Shared core definitions: datapath widths, load-type codes and the MEM->WB register layout.
package mem_wb_stage_pkg;

    localparam int RegBus     = 32;
    localparam int RegAddrBus = 5;

    localparam logic [RegBus-1:0] ZeroWord     = '0;
    localparam logic              WriteEnable  = 1'b1;
    localparam logic              WriteDisable = 1'b0;
    localparam logic              RstEnable    = 1'b1;

    typedef enum logic [2:0] {
        LD_NONE = 3'd0,
        LD_LB   = 3'd1,
        LD_LBU  = 3'd2,
        LD_LH   = 3'd3,
        LD_LHU  = 3'd4,
        LD_LW   = 3'd5,
        LD_LWL  = 3'd6,
        LD_LWR  = 3'd7
    } load_op_e;

    typedef struct packed {
        logic                  wreg;
        logic [RegAddrBus-1:0] waddr;
        load_op_e              load_op;
        logic [1:0]            byte_off;
        logic [RegBus-1:0]     rt_val;
        logic [RegBus-1:0]     wdata;
        logic                  whilo;
        logic [RegBus-1:0]     hi;
        logic [RegBus-1:0]     lo;
    } wb_reg_t;

    localparam wb_reg_t WB_BUBBLE = '0;

endpackage

// File: rtl/mem_wb_stage_if.sv
// MEM->WB bundle: pipeline control, MEM-stage results, data RAM return and WB outputs.
interface mem_wb_stage_if #(
    parameter int DW = 32,
    parameter int AW = 5
);
    logic          stall_mem;
    logic          stall_wb;
    logic          flush;
    logic          mem_wreg;
    logic [AW-1:0] mem_waddr;
    logic [DW-1:0] mem_wdata;
    logic [2:0]    mem_load_op;
    logic [1:0]    mem_byte_off;
    logic [DW-1:0] mem_rt_val;
    logic          mem_whilo;
    logic [DW-1:0] mem_hi;
    logic [DW-1:0] mem_lo;
    logic [DW-1:0] dmem_rdata;
    logic          wb_we;
    logic [AW-1:0] wb_waddr;
    logic [DW-1:0] wb_wdata;
    logic [DW-1:0] hi_o;
    logic [DW-1:0] lo_o;

    modport master (
        output stall_mem, stall_wb, flush, mem_wreg, mem_waddr, mem_wdata,
               mem_load_op, mem_byte_off, mem_rt_val, mem_whilo, mem_hi, mem_lo,
               dmem_rdata,
        input  wb_we, wb_waddr, wb_wdata, hi_o, lo_o
    );

    modport slave (
        input  stall_mem, stall_wb, flush, mem_wreg, mem_waddr, mem_wdata,
               mem_load_op, mem_byte_off, mem_rt_val, mem_whilo, mem_hi, mem_lo,
               dmem_rdata,
        output wb_we, wb_waddr, wb_wdata, hi_o, lo_o
    );
endinterface

// File: rtl/mem_wb_stage_hilo_reg.sv
// Architectural HI/LO pair: one write port, read port forwards the in-flight value when asked.
module mem_wb_stage_hilo_reg
    import mem_wb_stage_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic          byp,
    input  logic [DW-1:0] hi_i,
    input  logic [DW-1:0] lo_i,
    output logic [DW-1:0] hi_o,
    output logic [DW-1:0] lo_o
);

    logic [DW-1:0] hi_d, hi_q;
    logic [DW-1:0] lo_d, lo_q;

    always_comb begin
        hi_d = hi_q;
        lo_d = lo_q;
        if (we) begin
            hi_d = hi_i;
            lo_d = lo_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            hi_q <= '0;
            lo_q <= '0;
        end else begin
            hi_q <= hi_d;
            lo_q <= lo_d;
        end
    end

    assign hi_o = byp ? hi_i : hi_q;
    assign lo_o = byp ? lo_i : lo_q;

endmodule

// File: rtl/mem_wb_stage.sv
// MEM->WB pipeline register and write-back: big-endian load alignment and HI/LO commit.
module mem_wb_stage
    import mem_wb_stage_pkg::*;
#(
    parameter int DW = 32,
    parameter int AW = 5
) (
    input  logic          clk,
    input  logic          rst,
    mem_wb_stage_if.slave bus
);

    wb_reg_t wb_d, wb_q;
    wb_reg_t mem_in;
    logic    hilo_we;

    // Byte 0 is the most significant byte of the word.
    function automatic logic [DW-1:0] align_load(
        input load_op_e      op,
        input logic [1:0]    off,
        input logic [DW-1:0] m,
        input logic [DW-1:0] rt
    );
        logic [7:0]    b;
        logic [15:0]   h;
        logic [DW-1:0] r;
        case (off)
            2'd0:    b = m[31:24];
            2'd1:    b = m[23:16];
            2'd2:    b = m[15:8];
            default: b = m[7:0];
        endcase
        h = off[1] ? m[15:0] : m[31:16];
        r = m;
        case (op)
            LD_LB:  r = {{24{b[7]}}, b};
            LD_LBU: r = {24'h0, b};
            LD_LH:  r = {{16{h[15]}}, h};
            LD_LHU: r = {16'h0, h};
            LD_LW:  r = m;
            LD_LWL: begin
                case (off)
                    2'd0:    r = m;
                    2'd1:    r = {m[23:0], rt[7:0]};
                    2'd2:    r = {m[15:0], rt[15:0]};
                    default: r = {m[7:0], rt[23:0]};
                endcase
            end
            LD_LWR: begin
                case (off)
                    2'd0:    r = {rt[31:8], m[31:24]};
                    2'd1:    r = {rt[31:16], m[31:16]};
                    2'd2:    r = {rt[31:24], m[31:8]};
                    default: r = m;
                endcase
            end
            default: r = m;
        endcase
        return r;
    endfunction

    always_comb begin
        mem_in          = WB_BUBBLE;
        mem_in.wreg     = bus.mem_wreg;
        mem_in.waddr    = bus.mem_waddr;
        mem_in.load_op  = load_op_e'(bus.mem_load_op);
        mem_in.byte_off = bus.mem_byte_off;
        mem_in.rt_val   = bus.mem_rt_val;
        mem_in.wdata    = bus.mem_wdata;
        mem_in.whilo    = bus.mem_whilo;
        mem_in.hi       = bus.mem_hi;
        mem_in.lo       = bus.mem_lo;
    end

    always_comb begin
        wb_d = wb_q;
        if (bus.flush) begin
            wb_d = WB_BUBBLE;
        end else if (bus.stall_mem && !bus.stall_wb) begin
            wb_d = WB_BUBBLE;
        end else if (!bus.stall_mem) begin
            wb_d = mem_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            wb_q <= WB_BUBBLE;
        end else begin
            wb_q <= wb_d;
        end
    end

    // A flushed or stalled HI/LO writer must not commit; once released it commits exactly once.
    assign hilo_we = wb_q.whilo && !bus.stall_wb && !bus.flush;

    mem_wb_stage_hilo_reg #(.DW(DW)) u_hilo (
        .clk  (clk),
        .rst  (rst),
        .we   (hilo_we),
        .byp  (wb_q.whilo),
        .hi_i (wb_q.hi),
        .lo_i (wb_q.lo),
        .hi_o (bus.hi_o),
        .lo_o (bus.lo_o)
    );

    assign bus.wb_we    = wb_q.wreg ? WriteEnable : WriteDisable;
    assign bus.wb_waddr = wb_q.waddr[AW-1:0];
    assign bus.wb_wdata = (wb_q.load_op == LD_NONE) ? wb_q.wdata
                        : align_load(wb_q.load_op, wb_q.byte_off, bus.dmem_rdata, wb_q.rt_val);

endmodule
